// File: rtl/present_pkg.sv
// Shared types and helpers for the PRESENT-64 round engine.
// No ports; provides the round count, state width, FSM encoding and the
// pLayer bit permutation used by the datapath.
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int STATE_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } eng_state_e;

  // Bit i moves to (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] p;
    p = '0;
    for (int i = 0; i < 63; i++) begin
      p[6'((16 * i) % 63)] = s[i];
    end
    p[63] = s[63];
    return p;
  endfunction

endpackage

// File: rtl/present_key_update.sv
// PRESENT key schedule step: rotate, substitute top nibble(s), mix round counter.
// Latency: combinational. Backpressure: none.
// Ports: key = current round key register, round = round counter (low 5 bits),
//        next_key = key register value for the following round.
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       round,
  output logic [KEY_W-1:0] next_key
);

  // Rotate left by 61 positions.
  logic [KEY_W-1:0] rot;
  assign rot = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};

  if (KEY_W == 80) begin : g_k80
    logic [3:0] sb_hi;
    present_sbox u_sbox_hi (.x(rot[79:76]), .y(sb_hi));
    assign next_key = {sb_hi, rot[75:20], rot[19:15] ^ round, rot[14:0]};
  end else if (KEY_W == 128) begin : g_k128
    logic [3:0] sb_hi;
    logic [3:0] sb_lo;
    present_sbox u_sbox_hi (.x(rot[127:124]), .y(sb_hi));
    present_sbox u_sbox_lo (.x(rot[123:120]), .y(sb_lo));
    assign next_key = {sb_hi, sb_lo, rot[119:67], rot[66:62] ^ round, rot[61:0]};
  end else begin : g_bad_key_w
    $error("present_key_update: KEY_W must be 80 or 128");
    assign next_key = '0;
  end

endmodule

// File: rtl/present_sbox.sv
// PRESENT 4-bit substitution box.
// Latency: combinational. Backpressure: none.
// Ports: x = input nibble, y = substituted nibble.
module present_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);

  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-64 encryption: one round per clock, key schedule in lock-step.
// Latency: accept at edge N -> out_valid_o after edge N+31; 1 block per 32 cycles streaming.
// Backpressure: result held in DONE until out_ready_i; in_ready_o only in IDLE or
//               in DONE while the result is being taken (same-cycle reload, no bubble).
// Ports: clk_i/rst_ni (sync, active-low); in_valid_i/in_ready_o/data_i/key_i input
//        handshake; out_valid_o/out_ready_i/data_o output handshake; busy_o = rounds running.
module present_round_engine
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] data_i,
  input  logic [KEY_W-1:0]   key_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] data_o,
  output logic               busy_o
);

  eng_state_e         fsm_q;
  logic [5:0]         round_q;
  logic [STATE_W-1:0] state_q;
  logic [KEY_W-1:0]   key_q;

  logic [STATE_W-1:0] rk;
  logic [STATE_W-1:0] add_out;
  logic [STATE_W-1:0] sb_out;
  logic [KEY_W-1:0]   key_nxt;
  logic               accept;

  // The round key is always the top 64 bits of the key register. In DONE the
  // register holds K32, so the same XOR provides the output whitening.
  assign rk      = key_q[KEY_W-1 -: STATE_W];
  assign add_out = state_q ^ rk;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present_sbox u_sbox (.x(add_out[4*g +: 4]), .y(sb_out[4*g +: 4]));
  end

  present_key_update #(.KEY_W(KEY_W)) u_key_update (
    .key      (key_q),
    .round    (round_q[4:0]),
    .next_key (key_nxt)
  );

  assign in_ready_o  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready_i);
  assign out_valid_o = (fsm_q == DONE);
  assign busy_o      = (fsm_q == ROUND);
  assign data_o      = out_valid_o ? add_out : '0;
  assign accept      = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      case (fsm_q)
        ROUND: begin
          state_q <= p_layer(sb_out);
          key_q   <= key_nxt;
          round_q <= round_q + 6'd1;
          if (round_q == 6'(ROUNDS)) begin
            fsm_q <= DONE;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            state_q <= data_i;
            key_q   <= key_i;
            round_q <= 6'd1;
            fsm_q   <= ROUND;
          end else if ((fsm_q == DONE) && out_ready_i) begin
            fsm_q <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_round_engine.sv
// Bench for present_round_engine: known-answer table, random blocks against a
// behavioural PRESENT model, and hand-written handshake/reset corner sequences.
module tb_present_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // KEY_W = 80 instance
  logic         iv80, ir80, ov80, or80, busy80;
  logic [63:0]  d80, do80;
  logic [79:0]  k80;
  // KEY_W = 128 instance
  logic         iv128, ir128, ov128, or128, busy128;
  logic [63:0]  d128, do128;
  logic [127:0] k128;

  present_round_engine #(.KEY_W(80)) dut80 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv80), .in_ready_o(ir80), .data_i(d80), .key_i(k80),
    .out_valid_o(ov80), .out_ready_i(or80), .data_o(do80), .busy_o(busy80)
  );

  present_round_engine #(.KEY_W(128)) dut128 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv128), .in_ready_o(ir128), .data_i(d128), .key_i(k128),
    .out_valid_o(ov128), .out_ready_i(or128), .data_o(do128), .busy_o(busy128)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Straight textbook PRESENT: 31 rounds of (key add, sbox, permute) + final key add.
  function automatic logic [63:0] ref_enc(input int sel, input logic [63:0] pt,
                                          input logic [127:0] key);
    logic [63:0]  s, t, p;
    logic [79:0]  ka;
    logic [127:0] kb;
    logic [4:0]   rc;
    s  = pt;
    ka = key[79:0];
    kb = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ ((sel == 0) ? ka[79:16] : kb[127:64]);
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sb[s[4*n +: 4]];
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : ((16 * i) % 63)] = t[i];
      s  = p;
      rc = 5'(r);
      if (sel == 0) begin
        ka = (ka << 61) | (ka >> 19);
        ka[79:76] = sb[ka[79:76]];
        ka[19:15] = ka[19:15] ^ rc;
      end else begin
        kb = (kb << 61) | (kb >> 67);
        kb[127:124] = sb[kb[127:124]];
        kb[123:120] = sb[kb[123:120]];
        kb[66:62]   = kb[66:62] ^ rc;
      end
    end
    return s ^ ((sel == 0) ? ka[79:16] : kb[127:64]);
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? ov80 : ov128;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel == 0) ? ir80 : ir128;
  endfunction
  function automatic logic [63:0] get_do(input int sel);
    return (sel == 0) ? do80 : do128;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [63:0] d,
                          input logic [127:0] k);
    if (sel == 0) begin
      iv80 = v; d80 = d; k80 = k[79:0];
    end else begin
      iv128 = v; d128 = d; k128 = k;
    end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel == 0) or80 = r;
    else or128 = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the engine idle. Returns result and accept-to-valid cycles.
  task automatic run_block(input int sel, input logic [63:0] pt, input logic [127:0] key,
                           output logic [63:0] res, output int lat);
    drive_in(sel, 1'b1, pt, key);
    chk("in_ready_at_accept", 64'(get_ir(sel)), 64'd1);
    cyc();
    drive_in(sel, 1'b0, pt, key);
    lat = 0;
    while (!get_ov(sel) && lat < 100) begin
      cyc();
      lat++;
    end
    res = get_do(sel);
    set_ordy(sel, 1'b1);
    cyc();
    set_ordy(sel, 1'b0);
  endtask

  typedef struct {
    int           sel;
    logic [63:0]  pt;
    logic [127:0] key;
    logic [63:0]  exp;
  } vec_t;

  vec_t vt [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  res, exp, pt;
    logic [127:0] key;
    int           lat, cnt;
    logic         seen;

    vt[0] = '{0, 64'h0, 128'h0, 64'h5579C1387B228445};
    vt[1] = '{0, 64'h0, {48'h0, 80'hFFFF_FFFFFFFF_FFFFFFFF}, 64'hE72C46C0F5945049};
    vt[2] = '{0, 64'hFFFFFFFFFFFFFFFF, 128'h0, 64'hA112FFC72F68417B};
    vt[3] = '{0, 64'hFFFFFFFFFFFFFFFF, {48'h0, 80'hFFFF_FFFFFFFF_FFFFFFFF}, 64'h3333DCD3213210D2};
    vt[4] = '{1, 64'h0, 128'h0, 64'h96DB702A2E6900AF};

    rst_n = 1'b0;
    drive_in(0, 1'b0, 64'h0, 128'h0);
    drive_in(1, 1'b0, 64'h0, 128'h0);
    or80 = 1'b0;
    or128 = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_in_ready80", 64'(ir80), 64'd1);
    chk("rst_out_valid80", 64'(ov80), 64'd0);
    chk("rst_busy80", 64'(busy80), 64'd0);
    chk("rst_data80", do80, 64'd0);
    chk("rst_in_ready128", 64'(ir128), 64'd1);
    chk("rst_out_valid128", 64'(ov128), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Known-answer table
    for (int i = 0; i < 5; i++) begin
      run_block(vt[i].sel, vt[i].pt, vt[i].key, res, lat);
      chk($sformatf("kat%0d_data", i), res, vt[i].exp);
      chk($sformatf("kat%0d_latency", i), 64'(lat), 64'd31);
    end

    // Random blocks against the model
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = i % 2;
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      if (sel == 0) key[127:80] = '0;
      exp = ref_enc(sel, pt, key);
      run_block(sel, pt, key, res, lat);
      chk($sformatf("rnd%0d_data", i), res, exp);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd31);
    end

    // Hold in DONE, then same-cycle reload, then back-to-back spacing
    drive_in(0, 1'b1, vt[0].pt, vt[0].key);
    cyc();
    drive_in(0, 1'b0, vt[0].pt, vt[0].key);
    chk("busy_in_round", 64'(busy80), 64'd1);
    chk("in_ready_in_round", 64'(ir80), 64'd0);
    lat = 0;
    while (!ov80 && lat < 100) begin
      cyc();
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(ov80), 64'd1);
      chk("hold_data", do80, vt[0].exp);
      chk("hold_in_ready", 64'(ir80), 64'd0);
      cyc();
    end
    or80 = 1'b1;
    drive_in(0, 1'b1, vt[2].pt, vt[2].key);
    #1;
    chk("reload_in_ready_comb", 64'(ir80), 64'd1);
    cyc();
    or80 = 1'b0;
    drive_in(0, 1'b0, vt[2].pt, vt[2].key);
    chk("reload_busy", 64'(busy80), 64'd1);
    chk("reload_data_zero", do80, 64'd0);
    lat = 0;
    while (!ov80 && lat < 100) begin
      cyc();
      lat++;
    end
    chk("reload_latency", 64'(lat), 64'd31);
    chk("reload_data", do80, vt[2].exp);
    // Take it and immediately load the next: results 32 cycles apart
    or80 = 1'b1;
    drive_in(0, 1'b1, vt[1].pt, vt[1].key);
    cnt = 0;
    cyc();
    cnt++;
    or80 = 1'b0;
    drive_in(0, 1'b0, vt[1].pt, vt[1].key);
    while (!ov80 && cnt < 100) begin
      cyc();
      cnt++;
    end
    chk("b2b_spacing", 64'(cnt), 64'd32);
    chk("b2b_data", do80, vt[1].exp);
    or80 = 1'b1;
    cyc();
    or80 = 1'b0;
    chk("done_to_idle_ready", 64'(ir80), 64'd1);
    chk("done_to_idle_valid", 64'(ov80), 64'd0);

    // Reset in the middle of the rounds
    drive_in(0, 1'b1, vt[0].pt, vt[0].key);
    cyc();
    drive_in(0, 1'b0, vt[0].pt, vt[0].key);
    repeat (14) cyc();
    chk("mid_busy", 64'(busy80), 64'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 64'(ir80), 64'd1);
    chk("mid_rst_busy", 64'(busy80), 64'd0);
    chk("mid_rst_valid", 64'(ov80), 64'd0);
    chk("mid_rst_data", do80, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (ov80) seen = 1'b1;
      cyc();
    end
    chk("mid_rst_no_output", 64'(seen), 64'd0);
    run_block(0, vt[0].pt, vt[0].key, res, lat);
    chk("post_rst_data", res, vt[0].exp);
    chk("post_rst_latency", 64'(lat), 64'd31);

    // KEY_W=128: in_valid toggled with junk during ROUND must be ignored
    drive_in(1, 1'b1, 64'h0, 128'h0);
    cyc();
    lat = 0;
    while (!ov128 && lat < 100) begin
      drive_in(1, 1'($urandom_range(0, 1)), {$urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
      cyc();
      lat++;
    end
    drive_in(1, 1'b0, 64'h0, 128'h0);
    #1;
    chk("toggle128_latency", 64'(lat), 64'd31);
    chk("toggle128_data", do128, vt[4].exp);
    or128 = 1'b1;
    cyc();
    or128 = 1'b0;
    chk("toggle128_idle", 64'(ir128), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
